systolic_seq_ctrl: RTL and testbench

Sequencer for an N x N output-stationary MAC systolic array built from accumulate-in-place PEs. A PE loads a*b on `init` and emits its previous sum onto the output chain in the same cycle.
- Issues operand-buffer reads for T back-to-back tiles of reduction length K.
- Generates the per-anti-diagonal `init` wavefront matching the operand skew.
- Appends a flush wave so the last tile's sums leave the array.
- Counts drained results per column and flags which results are real.

---
 rtl/systolic_seq_ctrl_pkg.sv | 30 +++
 rtl/systolic_seq_ctrl_if.sv | 33 +++
 rtl/systolic_seq_ctrl_init_wave_delay.sv | 30 +++
 rtl/systolic_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing for the systolic array sequencer.
// Defaults match the standard 4x4 array configuration.
package systolic_seq_ctrl_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_KW     = 16;
  localparam int DEF_TW     = 16;
  localparam int DEF_AW     = 32;
  localparam int DEF_TMO    = 1024;

  localparam int DIAG_W = 2 * DEF_N - 1;
  localparam int DL_LEN = DEF_RD_LAT + DIAG_W;

  // Wide enough for (T_max+1)*N drained results per column
  function automatic int cntWidth(input int n, input int tw);
    return $clog2((2 ** tw) * n + 1);
  endfunction

  localparam int CNT_W = cntWidth(DEF_N, DEF_TW);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } seqState_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Control, operand-read and result-drain signals between host and sequencer.
interface systolic_seq_ctrl_if
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int KW = DEF_KW,
  parameter int TW = DEF_TW,
  parameter int AW = DEF_AW
);

  logic              start;
  logic [KW-1:0]     cfgKLen;
  logic [TW-1:0]     cfgNumTiles;
  logic              busy;
  logic              done;
  logic              err;
  logic              rdEn;
  logic [AW-1:0]     rdAddr;
  logic [2*N-2:0]    initDiag;
  logic [N-1:0]      resValid;
  logic [N-1:0]      resKeep;

  modport master (
    output start, cfgKLen, cfgNumTiles, resValid,
    input  busy, done, err, rdEn, rdAddr, initDiag, resKeep
  );

  modport slave (
    input  start, cfgKLen, cfgNumTiles, resValid,
    output busy, done, err, rdEn, rdAddr, initDiag, resKeep
  );

endinterface

// File: rtl/systolic_seq_ctrl_init_wave_delay.sv
// Delay line that turns one init pulse into the anti-diagonal wavefront,
// tap d firing RD_LAT+d cycles after the pulse.
module init_wave_delay
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int TAPS   = DIAG_W
) (
  input  logic            clk,
  input  logic            i_clear,
  input  logic            i_pulse,
  output logic [TAPS-1:0] o_taps
);

  localparam int LEN = RD_LAT + TAPS;

  // Bit k holds the pulse delayed by k cycles
  logic [LEN-1:1] r_line;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_line <= '0;
    end else begin
      r_line <= (r_line << 1) | (LEN-1)'(i_pulse);
    end
  end

  assign o_taps = r_line[LEN-1:RD_LAT];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary MAC array: streams T tiles of K operands,
// launches init wavefronts plus a flush wave, and tracks drained results.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int KW     = DEF_KW,
  parameter int TW     = DEF_TW,
  parameter int AW     = DEF_AW,
  parameter int TMO    = DEF_TMO
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_seq_ctrl_if.slave    io_bus
);

  localparam int W_DIAG = 2 * N - 1;
  localparam int W_CNT  = cntWidth(N, TW);
  localparam int W_WD   = $clog2(TMO + 1);

  seqState_t          r_state;
  seqState_t          w_nextState;
  logic [KW-1:0]      r_kLen;
  logic [KW-1:0]      r_kCnt;
  logic [TW-1:0]      r_numTiles;
  logic [TW-1:0]      r_tileCnt;
  logic [AW-1:0]      r_addr;
  logic [W_WD-1:0]    r_wdog;
  logic [W_CNT-1:0]   r_target;
  logic [W_CNT-1:0]   r_colCnt [N];
  logic [W_CNT-1:0]   w_colNext [N];
  logic               r_err;
  logic               w_rdEn;
  logic               w_inject;
  logic               w_counting;
  logic               w_kWrap;
  logic               w_lastFeed;
  logic               w_allFull;
  logic               w_timeout;
  logic               w_cfgBad;
  logic [N-1:0]       w_resKeep;
  logic [W_DIAG-1:0]  w_initDiag;

  assign w_cfgBad   = (io_bus.cfgKLen == '0) || (io_bus.cfgNumTiles == '0);
  assign w_kWrap    = (r_kCnt == r_kLen - KW'(1));
  assign w_lastFeed = w_kWrap && (r_tileCnt == r_numTiles - TW'(1));
  assign w_timeout  = (r_wdog == W_WD'(TMO - 1));
  assign w_counting = (r_state == FEED) || (r_state == FLUSH) || (r_state == DRAIN);

  // Drain completion looks at this cycle's strobes so done follows the last one directly
  always_comb begin
    w_allFull = 1'b1;
    w_resKeep = '0;
    for (int j = 0; j < N; j++) begin
      w_colNext[j] = r_colCnt[j];
      if (w_counting && io_bus.resValid[j] && (r_colCnt[j] != r_target)) begin
        w_colNext[j] = r_colCnt[j] + W_CNT'(1);
      end
      if (w_colNext[j] != r_target) begin
        w_allFull = 1'b0;
      end
      w_resKeep[j] = w_counting && io_bus.resValid[j] && (r_colCnt[j] >= W_CNT'(N));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_rdEn      = 1'b0;
    w_inject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_nextState = w_cfgBad ? DONE : FEED;
        end
      end
      FEED: begin
        w_rdEn   = 1'b1;
        w_inject = (r_kCnt == '0);
        if (w_lastFeed) begin
          w_nextState = FLUSH;
        end
      end
      FLUSH: begin
        w_inject    = 1'b1;
        w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_allFull || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kLen     <= '0;
      r_kCnt     <= '0;
      r_numTiles <= '0;
      r_tileCnt  <= '0;
      r_addr     <= '0;
      r_wdog     <= '0;
      r_target   <= '0;
      r_err      <= 1'b0;
      for (int j = 0; j < N; j++) begin
        r_colCnt[j] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_kLen     <= io_bus.cfgKLen;
            r_numTiles <= io_bus.cfgNumTiles;
            r_target   <= W_CNT'((32'(io_bus.cfgNumTiles) + 32'd1) * 32'(N));
            r_err      <= w_cfgBad;
            r_kCnt     <= '0;
            r_tileCnt  <= '0;
            r_addr     <= '0;
          end
        end
        FEED: begin
          r_addr <= r_addr + AW'(1);
          if (w_kWrap) begin
            r_kCnt    <= '0;
            r_tileCnt <= r_tileCnt + TW'(1);
          end else begin
            r_kCnt <= r_kCnt + KW'(1);
          end
        end
        FLUSH: begin
          r_wdog <= '0;
        end
        DRAIN: begin
          r_wdog <= r_wdog + W_WD'(1);
          if (!w_allFull && w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      for (int j = 0; j < N; j++) begin
        r_colCnt[j] <= (r_state == IDLE) ? '0 : w_colNext[j];
      end
    end
  end

  init_wave_delay #(
    .RD_LAT (RD_LAT),
    .TAPS   (W_DIAG)
  ) u_initWave (
    .clk     (clk),
    .i_clear (rst),
    .i_pulse (w_inject),
    .o_taps  (w_initDiag)
  );

  assign io_bus.busy     = (r_state != IDLE);
  assign io_bus.done     = (r_state == DONE);
  assign io_bus.err      = r_err;
  assign io_bus.rdEn     = w_rdEn;
  assign io_bus.rdAddr   = w_rdEn ? r_addr : '0;
  assign io_bus.initDiag = w_initDiag;
  assign io_bus.resKeep  = w_resKeep;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: directed scenarios with literal
// expectations plus randomized jobs checked every cycle against a job-timeline model.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  localparam int N      = DEF_N;
  localparam int RD_LAT = DEF_RD_LAT;
  localparam int TMO    = DEF_TMO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errCount   = 0;
  int   checkCount = 0;
  int   cyc        = 0;

  systolic_seq_ctrl_if io ();

  systolic_seq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (io)
  );

  always #5 clk = ~clk;

  // Reference model: a job is described by its accept cycle, K and T; everything
  // else follows from cycle offsets relative to that accept cycle.
  bit modelOn = 1'b0;
  bit mJob    = 1'b0;
  bit mGood   = 1'b0;
  bit mErr    = 1'b0;
  int mS      = 0;
  int mK      = 0;
  int mT      = 0;
  int mDoneAt = -1;
  int mTarget = 0;
  int mCnt [N];
  int mInj [$];

  function automatic bit mCounting(input int c);
    return mJob && mGood && ((c - mS) >= 1) && (mDoneAt < 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit s, input int k, input int t, input logic [N-1:0] v, input bit r);
    io.start       = s;
    io.cfgKLen     = k[DEF_KW-1:0];
    io.cfgNumTiles = t[DEF_TW-1:0];
    io.resValid    = v;
    rst            = r;
  endtask

  function automatic logic [N-1:0] randValid();
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[j] = ($urandom_range(0, 7) < 5);
    return v;
  endfunction

  always @(posedge clk) begin
    int cur;
    int rel;
    int feedLen;
    bit allFull;
    cur = cyc;
    if (rst) begin
      modelOn = 1'b1;
      mJob    = 1'b0;
      mErr    = 1'b0;
      mDoneAt = -1;
      mInj.delete();
    end else if (mJob) begin
      rel     = cur - mS;
      feedLen = mK * mT;
      if (mCounting(cur)) begin
        for (int j = 0; j < N; j++)
          if (io.resValid[j] && mCnt[j] < mTarget) mCnt[j]++;
        if (rel >= feedLen + 2) begin
          allFull = 1'b1;
          for (int j = 0; j < N; j++)
            if (mCnt[j] != mTarget) allFull = 1'b0;
          if (allFull) begin
            mDoneAt = cur + 1;
          end else if (rel - (feedLen + 2) + 1 == TMO) begin
            mDoneAt = cur + 1;
            mErr    = 1'b1;
          end
        end
      end else if (cur == mDoneAt) begin
        mJob = 1'b0;
      end
    end else if (io.start) begin
      mS      = cur;
      mK      = int'(io.cfgKLen);
      mT      = int'(io.cfgNumTiles);
      mJob    = 1'b1;
      mGood   = (mK != 0) && (mT != 0);
      mErr    = !mGood;
      mDoneAt = mGood ? -1 : cur + 1;
      mTarget = (mT + 1) * N;
      for (int j = 0; j < N; j++) mCnt[j] = 0;
    end
    if (mJob && mGood && mDoneAt < 0) begin
      rel = cur + 1 - mS;
      if ((rel >= 1 && rel <= mK * mT && ((rel - 1) % mK) == 0) || rel == mK * mT + 1)
        mInj.push_back(cur + 1);
    end
    while (mInj.size() > 0 && mInj[0] < cur - 3 * N - RD_LAT) void'(mInj.pop_front());
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int rel;
    bit eRd;
    logic [2*N-2:0] eDiag;
    logic [N-1:0] eKeep;
    if (modelOn && !rst) begin
      rel   = cyc - mS;
      eRd   = mJob && mGood && rel >= 1 && rel <= mK * mT;
      eDiag = '0;
      foreach (mInj[i])
        for (int d = 0; d < 2 * N - 1; d++)
          if (mInj[i] == cyc - RD_LAT - d) eDiag[d] = 1'b1;
      for (int j = 0; j < N; j++)
        eKeep[j] = mCounting(cyc) && io.resValid[j] && (mCnt[j] >= N);
      checkOutput("model busy", io.busy, mJob);
      checkOutput("model done", io.done, mJob && (cyc == mDoneAt));
      checkOutput("model err", io.err, mErr);
      checkOutput("model rdEn", io.rdEn, eRd);
      checkOutput("model rdAddr", io.rdAddr, eRd ? rel - 1 : 0);
      checkOutput("model initDiag", io.initDiag, eDiag);
      checkOutput("model resKeep", io.resKeep, eKeep);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int kk;
    int tt;
    int bound;
    applyStimulus(0, 0, 0, '0, 1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, '0, 0);
    @(negedge clk);
    checkOutput("reset busy", io.busy, 0);
    checkOutput("reset done", io.done, 0);
    checkOutput("reset err", io.err, 0);
    checkOutput("reset rdEn", io.rdEn, 0);
    checkOutput("reset initDiag", io.initDiag, 0);
    @(posedge clk); #1;

    $display("[TB] scenario 1: T=1 K=3");
    for (int r = 0; r <= 15; r++) begin
      applyStimulus(r == 0, 3, 1, (r >= 5 && r <= 12) ? {N{1'b1}} : {N{1'b0}}, 0);
      @(negedge clk);
      case (r)
        1: begin
          checkOutput("t1 rdEn first", io.rdEn, 1);
          checkOutput("t1 rdAddr first", io.rdAddr, 0);
        end
        2: checkOutput("t1 initDiag c2", io.initDiag, 7'h01);
        3: checkOutput("t1 rdAddr last", io.rdAddr, 2);
        5: begin
          checkOutput("t1 initDiag flush", io.initDiag, 7'h09);
          checkOutput("t1 resKeep first", io.resKeep, 0);
        end
        8: checkOutput("t1 initDiag c8", io.initDiag, 7'h48);
        9: checkOutput("t1 resKeep fifth", io.resKeep, 4'hF);
        12: checkOutput("t1 done early", io.done, 0);
        13: begin
          checkOutput("t1 done", io.done, 1);
          checkOutput("t1 err", io.err, 0);
        end
        14: checkOutput("t1 idle", io.busy, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] scenario 2: T=3 K=1");
    for (int r = 0; r <= 23; r++) begin
      applyStimulus(r == 0, 1, 3, (r >= 5 && r <= 20) ? {N{1'b1}} : {N{1'b0}}, 0);
      @(negedge clk);
      case (r)
        2: checkOutput("t2 initDiag c2", io.initDiag, 7'h01);
        3: begin
          checkOutput("t2 initDiag c3", io.initDiag, 7'h03);
          checkOutput("t2 rdAddr c3", io.rdAddr, 2);
        end
        4: checkOutput("t2 rdEn off", io.rdEn, 0);
        5: checkOutput("t2 initDiag c5", io.initDiag, 7'h0F);
        20: checkOutput("t2 done early", io.done, 0);
        21: checkOutput("t2 done", io.done, 1);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] scenario 3: K=0 config error");
    for (int r = 0; r <= 3; r++) begin
      applyStimulus(r == 0, 0, 2, '0, 0);
      @(negedge clk);
      case (r)
        1: begin
          checkOutput("t3 done", io.done, 1);
          checkOutput("t3 err", io.err, 1);
          checkOutput("t3 rdEn", io.rdEn, 0);
        end
        2: checkOutput("t3 idle", io.busy, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] scenario 4: drain watchdog");
    for (int r = 0; r <= 1031; r++) begin
      applyStimulus(r == 0, 2, 1, '0, 0);
      @(negedge clk);
      case (r)
        1027: checkOutput("t4 done early", io.done, 0);
        1028: begin
          checkOutput("t4 done", io.done, 1);
          checkOutput("t4 err", io.err, 1);
        end
        1031: checkOutput("t4 err held", io.err, 1);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] scenario 5: start while busy, then reset mid-job");
    for (int r = 0; r <= 14; r++) begin
      applyStimulus(r <= 1, (r == 1) ? 7 : 4, (r == 1) ? 5 : 2, '0, r == 2);
      @(negedge clk);
      case (r)
        1: checkOutput("t5 err cleared", io.err, 0);
        2: checkOutput("t5 rdAddr c2", io.rdAddr, 1);
        3: begin
          checkOutput("t5 busy after rst", io.busy, 0);
          checkOutput("t5 rdEn after rst", io.rdEn, 0);
          checkOutput("t5 initDiag after rst", io.initDiag, 0);
        end
        6: checkOutput("t5 no stale wave", io.initDiag, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] scenario 6: simultaneous column strobes");
    for (int r = 0; r <= 14; r++) begin
      applyStimulus(r == 0, 2, 1, (r >= 4 && r <= 11) ? {N{1'b1}} : {N{1'b0}}, 0);
      @(negedge clk);
      case (r)
        4: checkOutput("t6 resKeep c4", io.resKeep, 0);
        7: checkOutput("t6 resKeep c7", io.resKeep, 0);
        8: checkOutput("t6 resKeep c8", io.resKeep, 4'hF);
        11: begin
          checkOutput("t6 resKeep c11", io.resKeep, 4'hF);
          checkOutput("t6 done early", io.done, 0);
        end
        12: checkOutput("t6 done", io.done, 1);
        13: checkOutput("t6 single done", io.done, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end

    $display("[TB] randomized jobs");
    for (int job = 0; job < 30; job++) begin
      kk = $urandom_range(0, 4);
      tt = $urandom_range(0, 3);
      applyStimulus(1, kk, tt, randValid(), 0);
      @(posedge clk); #1;
      bound = 0;
      while (io.busy && bound < 300) begin
        applyStimulus($urandom_range(0, 3) == 0, int'($urandom), int'($urandom), randValid(), 0);
        @(posedge clk); #1;
        bound++;
      end
      checkOutput("random job ends", io.busy, 0);
      repeat ($urandom_range(0, 3)) begin
        applyStimulus(0, 0, 0, randValid(), 0);
        @(posedge clk); #1;
      end
    end

    applyStimulus(0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
